// File: rtl/ripple_cnt_ctrl_pkg.sv
// Shared types and constants for the ripple counter sequencer.
package ripple_cnt_pkg;

  localparam int unsigned DEF_WIDTH      = 4;
  localparam int unsigned DEF_SETTLE_CYC = 2;
  localparam int unsigned SETTLE_W       = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    TICK   = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/ripple_cnt_ctrl_if.sv
// Control/status bundle between system logic, the sequencer and the counter chain.
interface ripple_cnt_ctrl_if
  import ripple_cnt_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] target;
  logic             abort;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_clr;
  logic             cnt_tick;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count_out;
  logic             err;

  modport slave (
    input  start, target, abort, cnt_q,
    output cnt_clr, cnt_tick, busy, done, count_out, err
  );

  modport master (
    output start, target, abort, cnt_q,
    input  cnt_clr, cnt_tick, busy, done, count_out, err
  );
endinterface

// File: rtl/ripple_cnt_ctrl_settle_timer.sv
// Load/decrement down-counter; expired is high while the count is zero.
module settle_timer
  import ripple_cnt_pkg::*;
#(
  parameter int unsigned W = SETTLE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/ripple_cnt_ctrl.sv
// Sequencer for an external ripple counter: clear, strobe, settle, sample.
// Define RIPPLE_CNT_CHECK_EN to compare sampled values and raise a sticky err.
module ripple_cnt_ctrl
  import ripple_cnt_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              reset,
  ripple_cnt_ctrl_if.slave  bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             clr, tick, done, busy;
  logic             tmr_load, tmr_expired;
`ifdef RIPPLE_CNT_CHECK_EN
  logic             err_q, err_d;
`endif

  // Timer holds SETTLE_CYC-1 in the first SETTLE cycle, so SETTLE lasts SETTLE_CYC cycles.
  settle_timer #(.W(SETTLE_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_W'(SETTLE_CYC - 1)),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    expected_d = expected_q;
    count_d    = count_q;
`ifdef RIPPLE_CNT_CHECK_EN
    err_d      = err_q;
`endif
    tmr_load   = 1'b0;
    clr        = 1'b0;
    tick       = 1'b0;
    done       = 1'b0;
    busy       = (state_q != IDLE);

    unique case (state_q)
      IDLE: if (bus.start) begin
        target_d   = bus.target;
        expected_d = '0;
`ifdef RIPPLE_CNT_CHECK_EN
        err_d      = 1'b0;
`endif
        state_d    = CLEAR;
      end
      CLEAR: begin
        clr      = 1'b1;
        tmr_load = 1'b1;
        state_d  = SETTLE;
      end
      SETTLE: if (tmr_expired) state_d = CHECK;
      CHECK: begin
        count_d = bus.cnt_q;
`ifdef RIPPLE_CNT_CHECK_EN
        if (bus.cnt_q != expected_q) err_d = 1'b1;
`endif
        state_d = (expected_q == target_q) ? DONE : TICK;
      end
      TICK: begin
        tick       = 1'b1;
        tmr_load   = 1'b1;
        expected_d = expected_q + 1'b1;
        state_d    = SETTLE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides the case above: strobes are gated in the same cycle and
    // all result registers keep their current values.
    if (bus.abort && (state_q inside {CLEAR, SETTLE, CHECK, TICK})) begin
      state_d    = IDLE;
      clr        = 1'b0;
      tick       = 1'b0;
      tmr_load   = 1'b0;
      expected_d = expected_q;
      count_d    = count_q;
`ifdef RIPPLE_CNT_CHECK_EN
      err_d      = err_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      target_q   <= '0;
      expected_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      expected_q <= expected_d;
      count_q    <= count_d;
    end
  end

`ifdef RIPPLE_CNT_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.cnt_clr   = clr;
  assign bus.cnt_tick  = tick;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.count_out = count_q;
endmodule

// File: tb/tb_ripple_cnt_ctrl.sv
// Directed bench for ripple_cnt_ctrl (WIDTH=4, SETTLE_CYC=2) with a behavioural counter model.
module tb_ripple_cnt_ctrl;
  localparam int S = 2;
`ifdef RIPPLE_CNT_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] model_q;
  bit         stuck;
  int         checks = 0;
  int         errors = 0;

  ripple_cnt_ctrl_if #(.WIDTH(4)) bus ();

  ripple_cnt_ctrl #(.WIDTH(4), .SETTLE_CYC(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Ideal counter chain; the stuck mode forces bit 1 low on the outputs.
  always @(posedge clk) begin
    if (reset)             model_q <= '0;
    else if (bus.cnt_clr)  model_q <= '0;
    else if (bus.cnt_tick) model_q <= model_q + 4'd1;
  end
  assign bus.cnt_q = stuck ? (model_q & 4'b1101) : model_q;

  typedef struct {
    logic [3:0] target;
    bit         stuck;
    int         exp_ticks;
    int         exp_lat;
    int         exp_count;
    int         exp_err;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one sequence; cycle n=1 is the first cycle after the accepting edge.
  task automatic run_seq(input logic [3:0] t, input int repulse_n,
                         output int lat, output int ticks);
    int clrs = 0;
    int n = 1;
    bit seen = 0;
    ticks = 0;
    lat = -1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.target = t;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.target = 4'd0;
    check("err_clear_on_start", int'(bus.err), 0);
    while (n < 200 && !seen) begin
      if (bus.cnt_clr) begin
        clrs++;
        check("clr_pos", n, 1);
      end
      if (bus.cnt_tick) begin
        ticks++;
        check("tick_pos", n, 1 + ticks * (S + 2));
      end
      if (n == repulse_n) begin
        bus.start = 1'b1; bus.target = 4'd7;
      end else if (n == repulse_n + 1) begin
        bus.start = 1'b0; bus.target = 4'd0;
      end
      if (bus.done) begin
        seen = 1;
        lat = n;
        check("busy_in_done", int'(bus.busy), 1);
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("done_seen", int'(seen), 1);
    check("clr_count", clrs, 1);
    @(posedge clk); #1;
    check("busy_after_done", int'(bus.busy), 0);
    check("done_one_cycle", int'(bus.done), 0);
  endtask

  task automatic run_abort(input logic [3:0] t, input int abort_n, input int exp_cnt);
    int n = 1;
    int stray = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.target = t;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (n < abort_n) begin
      @(posedge clk); #1;
      n++;
    end
    bus.abort = 1'b1;
    #1;
    check("abort_gate_tick", int'(bus.cnt_tick), 0);
    check("abort_gate_clr", int'(bus.cnt_clr), 0);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_count_hold", int'(bus.count_out), exp_cnt);
    repeat (20) begin
      if (bus.cnt_tick || bus.done || bus.cnt_clr) stray++;
      @(posedge clk); #1;
    end
    check("abort_quiet", stray, 0);
  endtask

  initial begin
    int lat, ticks, pulses, n;
    reset = 1'b1; stuck = 0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.target = 4'd0;
    vecs[0] = '{4'd3,  1'b0, 3,  17, 3,  0};
    vecs[1] = '{4'd0,  1'b0, 0,  5,  0,  0};
    vecs[2] = '{4'd1,  1'b0, 1,  9,  1,  0};
    vecs[3] = '{4'd15, 1'b0, 15, 65, 15, 0};
    vecs[4] = '{4'd2,  1'b1, 2,  13, 0,  ERR_EXP};
    vecs[5] = '{4'd2,  1'b0, 2,  13, 2,  0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_clr", int'(bus.cnt_clr), 0);
    check("rst_tick", int'(bus.cnt_tick), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_count", int'(bus.count_out), 0);
    check("rst_err", int'(bus.err), 0);
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.cnt_clr || bus.cnt_tick || bus.busy) pulses++;
    end
    check("idle_quiet", pulses, 0);

    for (int i = 0; i < 6; i++) begin
      stuck = vecs[i].stuck;
      run_seq(vecs[i].target, 0, lat, ticks);
      check("latency", lat, vecs[i].exp_lat);
      check("ticks", ticks, vecs[i].exp_ticks);
      check("count_out", int'(bus.count_out), vecs[i].exp_count);
      check("err", int'(bus.err), vecs[i].exp_err);
    end
    stuck = 0;

    run_seq(4'd3, 6, lat, ticks);
    check("repulse_latency", lat, 17);
    check("repulse_ticks", ticks, 3);
    check("repulse_count", int'(bus.count_out), 3);

    run_abort(4'd5, 10, 1);
    run_seq(4'd1, 0, lat, ticks);
    check("post_abort_latency", lat, 9);
    check("post_abort_count", int'(bus.count_out), 1);
    run_abort(4'd5, 13, 2);

    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b1; bus.target = 4'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    #1;
    check("start_wins_busy", int'(bus.busy), 1);
    check("start_wins_clr", int'(bus.cnt_clr), 1);
    n = 1;
    while (n < 50 && !bus.done) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_wins_done", n, 5);

    @(posedge clk); #1;
    bus.start = 1'b1; bus.target = 4'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mrst_clr", int'(bus.cnt_clr), 0);
    check("mrst_tick", int'(bus.cnt_tick), 0);
    check("mrst_busy", int'(bus.busy), 0);
    check("mrst_done", int'(bus.done), 0);
    check("mrst_count", int'(bus.count_out), 0);
    check("mrst_err", int'(bus.err), 0);
    reset = 1'b0;
    run_seq(4'd2, 0, lat, ticks);
    check("post_rst_latency", lat, 13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
